// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter slice: width default,
// binary-to-Gray conversion and popcount.
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 4;
    localparam int GRAY_W_MAX     = 32;

    // Width-generic conversion: callers zero-extend a WIDTH-bit value to
    // GRAY_W_MAX bits and keep the low WIDTH bits of the result. The upper
    // bits stay zero, so the low slice is the WIDTH-bit Gray code.
    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Number of set bits in v.
    function automatic int unsigned popcount(input logic [GRAY_W_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < GRAY_W_MAX; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_step_check.sv
// Step checker for the Gray output, built only when GRAY_CHECK_EN is defined.
// Flags any cycle in which g moves by more than one bit, except the cycle
// right after a load or reset, where a multi-bit jump is legitimate.
module gray_step_check
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g,
    input  logic             first,
    output logic             err
);

    logic [WIDTH-1:0] g_prev;

    // Track previous g and latch a sticky error on an illegal multi-bit step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_prev <= '0;
            err    <= 1'b0;
        end else begin
            g_prev <= g;
            if (!first && popcount(GRAY_W_MAX'(g ^ g_prev)) > 32'd1) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Registered Gray-code up/down counter with synchronous load, enable,
// direction, combinational terminal count and a registered wrap pulse.
// Optional feature: define GRAY_CHECK_EN to add the step checker and err port.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             wrap
`ifdef GRAY_CHECK_EN
    ,
    output logic             err
`endif
);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        logic [GRAY_W_MAX-1:0] t;
        t = bin2gray(GRAY_W_MAX'(b));
        return t[WIDTH-1:0];
    endfunction

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_GRAY = to_gray(INIT_BIN);

    logic [WIDTH-1:0] bin_next;
    logic             wrap_next;

    // Next-count selection: load beats en, en beats hold.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; a missing
        // branch would otherwise infer a latch.
        bin_next  = bin;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_val;
        end else if (en) begin
            if (up_dn) begin
                bin_next  = bin + ONE;
                wrap_next = (bin == ALL_ONES);
            end else begin
                bin_next  = bin - ONE;
                wrap_next = (bin == '0);
            end
        end
    end

    // Terminal count looks at the current state and the step about to happen.
    assign tc = en & ~load & ((up_dn & (bin == ALL_ONES)) | (~up_dn & (bin == '0)));

    // Count state; g is derived from bin_next so it lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so all registers update together
        // from pre-edge values, independent of statement order.
        if (!rst_n) begin
            bin  <= INIT_BIN;
            g    <= INIT_GRAY;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_next;
            g    <= to_gray(bin_next);
            wrap <= wrap_next;
        end
    end

`ifdef GRAY_CHECK_EN
    logic first_q;

    // Marks the cycle after a load or reset, where g may jump freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b1;
        end else begin
            first_q <= load;
        end
    end

    gray_step_check #(
        .WIDTH (WIDTH)
    ) u_step_check (
        .clk   (clk),
        .rst_n (rst_n),
        .g     (g),
        .first (first_q),
        .err   (err)
    );
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4, INIT=0).
// Reference model counts with modular integer arithmetic and looks Gray codes
// up in a table built by reflection; define GRAY_CHECK_EN to also exercise err.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'h0;
    logic [3:0] g;
    logic [3:0] bin;
    logic       tc;
    logic       wrap;
`ifdef GRAY_CHECK_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    int gray_tab [16];
    int m_bin  = 0;
    bit m_wrap = 1'b0;

    gray_counter #(
        .WIDTH (4),
        .INIT  (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .g        (g),
        .bin      (bin),
        .tc       (tc),
        .wrap     (wrap)
`ifdef GRAY_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step: drive inputs, check tc mid-cycle, then outputs after the edge.
    task automatic step(input bit e, input bit u, input bit l, input int lv, input string tag);
        logic [3:0] prev_g;
        bit         exp_tc;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = 4'(lv);
        @(negedge clk);
        exp_tc = e && !l && ((u && m_bin == 15) || (!u && m_bin == 0));
        check({tag, ":tc"}, 32'(tc), 32'(exp_tc));
        prev_g = g;
        @(posedge clk);
        #1;
        if (l) begin
            m_bin  = lv;
            m_wrap = 1'b0;
        end else if (e) begin
            m_wrap = u ? (m_bin == 15) : (m_bin == 0);
            m_bin  = u ? (m_bin + 1) % 16 : (m_bin + 15) % 16;
        end else begin
            m_wrap = 1'b0;
        end
        check({tag, ":bin"}, 32'(bin), 32'(m_bin));
        check({tag, ":g"}, 32'(g), 32'(gray_tab[m_bin]));
        check({tag, ":wrap"}, 32'(wrap), 32'(m_wrap));
        if (!l) begin
            check({tag, ":onebit"}, 32'($countones(g ^ prev_g) <= 1), 32'd1);
        end
    endtask

    int up_seq [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        // Reflected Gray table: second half is the first half mirrored plus the new MSB.
        gray_tab[0] = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gray_tab[(1 << k) + i] = (1 << k) | gray_tab[(1 << k) - 1 - i];
            end
        end

        // Reset state
        #2;
        check("reset:bin", 32'(bin), 32'd0);
        check("reset:g", 32'(g), 32'd0);
        check("reset:wrap", 32'(wrap), 32'd0);
        check("reset:tc", 32'(tc), 32'd0);
`ifdef GRAY_CHECK_EN
        check("reset:err", 32'(err), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full up sequence with wrap from F to 0
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 0, "up");
            check("up:seq", 32'(g), 32'(up_seq[i]));
        end

        // Down from 0 wraps to F
        step(1'b1, 1'b0, 1'b0, 0, "down_wrap");
        check("down_wrap:g8", 32'(g), 32'h8);
        step(1'b0, 1'b0, 1'b0, 0, "hold");

        // Load beats en, then one up step
        step(1'b1, 1'b1, 1'b1, 5, "load5");
        check("load5:g7", 32'(g), 32'h7);
        step(1'b1, 1'b1, 1'b0, 0, "after_load");
        check("after_load:g5", 32'(g), 32'h5);
        step(1'b0, 1'b0, 1'b1, 6, "load_same");

        // Direction toggling from 3
        step(1'b0, 1'b0, 1'b1, 3, "load3");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i % 2 == 0), 1'b0, 0, "toggle");
            check("toggle:g", 32'(g), (i % 2 == 0) ? 32'h6 : 32'h2);
        end

        // Asynchronous reset while counting at A
        step(1'b0, 1'b0, 1'b1, 9, "load9");
        step(1'b1, 1'b1, 1'b0, 0, "toA");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst:bin", 32'(bin), 32'd0);
        check("async_rst:g", 32'(g), 32'd0);
        check("async_rst:wrap", 32'(wrap), 32'd0);
        m_bin  = 0;
        m_wrap = 1'b0;
        @(posedge clk);
        #1;
        check("rst_held:bin", 32'(bin), 32'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 0, "resume");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)), "rand");
        end

`ifdef GRAY_CHECK_EN
        // Illegal two-bit jump 3 -> 0 sets err, which stays until reset
        step(1'b0, 1'b0, 1'b1, 2, "chk_load2");
        step(1'b0, 1'b0, 1'b0, 0, "chk_hold");
        check("chk:pre_err", 32'(err), 32'd0);
        force dut.g = 4'h0;
        @(posedge clk);
        #1;
        release dut.g;
        @(posedge clk);
        #1;
        check("chk:err_set", 32'(err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("chk:err_sticky", 32'(err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("chk:err_rst", 32'(err), 32'd0);
        m_bin  = 0;
        m_wrap = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Legal load jump 2 -> D
        step(1'b0, 1'b0, 1'b1, 3, "chk_load3");
        step(1'b0, 1'b0, 1'b1, 9, "chk_load9");
        step(1'b0, 1'b0, 1'b0, 0, "chk_hold2");
        step(1'b0, 1'b0, 1'b0, 0, "chk_hold3");
        check("chk:load_ok", 32'(err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered Gray-code up/down counter; the source stage feeding the 4-bit Gray-to-binary converter.
- Keeps a binary state internally and drives a registered Gray output, so exactly one output bit changes per step.
- Supports synchronous load, count enable, direction select, terminal-count flag and wrap pulse.

Parameters:
- WIDTH, 4, counter and Gray output width (>=2).
- INIT, 0, binary value loaded at reset (0..2^WIDTH-1).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe; overrides en.
- load_val  input  WIDTH  binary value to load.
- g  output  WIDTH  registered Gray code of the current count.
- bin  output  WIDTH  registered binary count, exposed for checking.
- tc  output  1  combinational terminal count: en & !load & ((up_dn & bin==all-ones) | (!up_dn & bin==0)).
- wrap  output  1  registered one-cycle pulse, high in the cycle after a count step wrapped.
- err  output  1  sticky step-violation flag; exists only with GRAY_CHECK_EN.

Behaviour:
- Reset (rst_n low, asynchronous): bin=INIT, g=INIT^(INIT>>1), wrap=0, err=0. Release is synchronous to clk.
- Priority per edge: load > en > hold.
  - load: bin<=load_val, g<=load_val^(load_val>>1), wrap<=0.
  - en & up_dn: bin<=bin+1 modulo 2^WIDTH.
  - en & !up_dn: bin<=bin-1 modulo 2^WIDTH.
  - hold: bin and g unchanged, wrap<=0.
- g is always updated in the same edge as bin and is computed from the next bin value. There is no combinational path from inputs to g.
- Latency: a step applied at edge N is visible on g and bin after edge N. tc is combinational from the current bin, en, load and up_dn.
- Wrap: an up step from all-ones to 0, or a down step from 0 to all-ones, sets wrap<=1 for exactly one cycle. Continuous counting gives one wrap pulse every 2^WIDTH cycles.
- Direction change mid-count is allowed; the next step uses the new up_dn. g still changes by exactly one bit.
- Load together with en: load wins and no step occurs. Loading the current value leaves g unchanged.
- Reset asserted mid-count: all outputs return immediately to reset values, with no wait for clk.
- Arithmetic is unsigned, WIDTH bits, and overflow is discarded.

Optional Feature:
- Macro: GRAY_CHECK_EN.
- With it:
  - Adds a registered copy of the previous g.
  - In any cycle not following a load or reset, popcount(g ^ g_prev) must be 0 or 1. Otherwise err<=1 and stays set until rst_n.
  - Adds port err.
- Without it: no checker logic and no err port; the rest of the interface is unchanged.

Decomposition:
- Shared package gray_pkg holds:
  - the bin2gray function, parameterised by width;
  - the popcount function;
  - GRAY_W_DEFAULT=4.
- Sub-module gray_step_check holds the GRAY_CHECK_EN checker (g in, first-after-load qualifier in, err out). It is instantiated only when the macro is defined.

Test Plan:
- Reset then en=1, up_dn=1 for 17 cycles -> g sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. wrap pulses once after the F->0 binary step. tc is high in the cycle bin=F.
- From bin=0, en=1, up_dn=0 -> g: 0 -> 8 (bin F); wrap pulses one cycle; tc is high in the bin=0 cycle.
- load=1, load_val=5, en=1 together -> bin=5, g=7, no step, wrap=0. Then one up step -> bin=6, g=5.
- en=1 with up_dn toggled every cycle starting from bin=3 -> bin alternates 4,3,4,3. g alternates 6,2, with a single-bit change each cycle.
- rst_n pulled low mid-cycle during counting at bin=A -> g and bin go to INIT encoding asynchronously. Counting resumes from INIT after release.
- GRAY_CHECK_EN: force an illegal g jump via a bench override (3->0, two bits) -> err=1, sticky until reset. A legal load jump 2->D does not set err.
